// File: rtl/tcdm2axi_pkg.sv
// Shared types and AXI encodings for the TCDM-to-AXI master bridge.
// Only constants, the controller state type and a response helper; no logic.
package tcdm2axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  // SLVERR and DECERR are the only AXI responses with bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/tcdm2axi_err_log.sv
// Sticky log of the first AXI error response (address and direction).
// One-cycle update latency; a clear coinciding with a new error keeps the new error.
module tcdm2axi_err_log
  import tcdm2axi_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              err_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              is_write_i,
  input  logic              clr_i,
  output logic              err_valid_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              err_is_write_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_write_q, is_write_d;

  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    is_write_d = is_write_q;
    if (err_i && (!valid_q || clr_i)) begin
      valid_d    = 1'b1;
      addr_d     = addr_i;
      is_write_d = is_write_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      addr_q     <= '0;
      is_write_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      is_write_q <= is_write_d;
    end
  end

  assign err_valid_o    = valid_q;
  assign err_addr_o     = addr_q;
  assign err_is_write_o = is_write_q;

endmodule

// File: rtl/tcdm_to_axi_master_bridge.sv
// TCDM slave port to single-beat AXI4 master, one transaction outstanding; optional error log under TCDM2AXI_ERR_LOG_EN.
// Zero-wait latency: gnt c0, AW/W c1, B c2, r_valid c3; TCDM gnt is held low until the response pulse is done.
module tcdm_to_axi_master_bridge
  import tcdm2axi_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter logic [2:0]  AXI_PROT       = 3'b000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tcdm_req_i,
  input  logic [31:0]               tcdm_add_i,
  input  logic                      tcdm_wen_i,
  input  logic [31:0]               tcdm_wdata_i,
  input  logic [3:0]                tcdm_be_i,
  output logic                      tcdm_gnt_o,
  output logic                      tcdm_r_valid_o,
  output logic [31:0]               tcdm_r_rdata_o,
  output logic                      tcdm_r_opc_o,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [31:0]               aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   aw_id_o,
  output logic [7:0]                aw_len_o,
  output logic [2:0]                aw_size_o,
  output logic [1:0]                aw_burst_o,
  output logic                      aw_lock_o,
  output logic [3:0]                aw_cache_o,
  output logic [2:0]                aw_prot_o,
  output logic [3:0]                aw_qos_o,
  output logic [3:0]                aw_region_o,
  output logic [AXI_USER_WIDTH-1:0] aw_user_o,
  output logic [5:0]                aw_atop_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [31:0]               w_data_o,
  output logic [3:0]                w_strb_o,
  output logic                      w_last_o,
  output logic [AXI_USER_WIDTH-1:0] w_user_o,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [1:0]                b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   b_id_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [31:0]               ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  output logic                      ar_lock_o,
  output logic [3:0]                ar_cache_o,
  output logic [2:0]                ar_prot_o,
  output logic [3:0]                ar_qos_o,
  output logic [3:0]                ar_region_o,
  output logic [AXI_USER_WIDTH-1:0] ar_user_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [31:0]               r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   r_id_i,
  input  logic                      r_last_i
`ifdef TCDM2AXI_ERR_LOG_EN
  ,
  output logic                      err_valid_o,
  output logic [31:0]               err_addr_o,
  output logic                      err_is_write_o,
  input  logic                      err_clr_i
`endif
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   be_q, be_d;
  logic                wen_q, wen_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                opc_q, opc_d;
  logic                gnt;
  logic                err_evt;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    wen_d          = wen_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    rdata_d        = rdata_q;
    opc_d          = opc_q;
    gnt            = 1'b0;
    aw_valid_o     = 1'b0;
    w_valid_o      = 1'b0;
    b_ready_o      = 1'b0;
    ar_valid_o     = 1'b0;
    r_ready_o      = 1'b0;
    tcdm_r_valid_o = 1'b0;
    err_evt        = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt = tcdm_req_i;
        if (tcdm_req_i) begin
          addr_d    = tcdm_add_i;
          wdata_d   = tcdm_wdata_i;
          be_d      = tcdm_be_i;
          wen_d     = tcdm_wen_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = tcdm_wen_i ? RD_ADDR : WRITE;
        end
      end
      WRITE: begin
        // AW and W retire independently; leave only once both have handshaken.
        aw_valid_o = !aw_done_q;
        w_valid_o  = !w_done_q;
        if (aw_ready_i) aw_done_d = 1'b1;
        if (w_ready_i)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_ready_i) && (w_done_q || w_ready_i)) state_d = WR_RESP;
      end
      WR_RESP: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          rdata_d = '0;
          opc_d   = resp_is_err(b_resp_i);
          err_evt = resp_is_err(b_resp_i);
          state_d = RESP;
        end
      end
      RD_ADDR: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        r_ready_o = 1'b1;
        if (r_valid_i) begin
          rdata_d = r_data_i;
          opc_d   = resp_is_err(r_resp_i);
          err_evt = resp_is_err(r_resp_i);
          state_d = RESP;
        end
      end
      RESP: begin
        tcdm_r_valid_o = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wen_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      opc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      wen_q     <= wen_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      opc_q     <= opc_d;
    end
  end

  assign tcdm_gnt_o     = gnt && !rst_i;
  assign tcdm_r_rdata_o = rdata_q;
  assign tcdm_r_opc_o   = opc_q;

  assign aw_addr_o   = addr_q;
  assign aw_id_o     = '0;
  assign aw_len_o    = 8'd0;
  assign aw_size_o   = AXI_SIZE_4B;
  assign aw_burst_o  = AXI_BURST_INCR;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = 4'd0;
  assign aw_prot_o   = AXI_PROT;
  assign aw_qos_o    = 4'd0;
  assign aw_region_o = 4'd0;
  assign aw_user_o   = '0;
  assign aw_atop_o   = 6'd0;

  assign w_data_o = wdata_q;
  assign w_strb_o = be_q;
  assign w_last_o = w_valid_o;
  assign w_user_o = '0;

  assign ar_addr_o   = addr_q;
  assign ar_id_o     = '0;
  assign ar_len_o    = 8'd0;
  assign ar_size_o   = AXI_SIZE_4B;
  assign ar_burst_o  = AXI_BURST_INCR;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = 4'd0;
  assign ar_prot_o   = AXI_PROT;
  assign ar_qos_o    = 4'd0;
  assign ar_region_o = 4'd0;
  assign ar_user_o   = '0;

  // IDs, the low response bit and r_last carry nothing for single-beat, ID-0 traffic.
  logic unused_in;
  assign unused_in = ^{b_id_i, r_id_i, r_last_i, b_resp_i[0], r_resp_i[0]};

`ifdef TCDM2AXI_ERR_LOG_EN
  tcdm2axi_err_log u_err_log (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .err_i          (err_evt),
    .addr_i         (addr_q),
    .is_write_i     (!wen_q),
    .clr_i          (err_clr_i),
    .err_valid_o    (err_valid_o),
    .err_addr_o     (err_addr_o),
    .err_is_write_o (err_is_write_o)
  );
`else
  logic unused_err;
  assign unused_err = err_evt;
`endif

endmodule

// File: doc/tcdm_to_axi_master_bridge.md
Name: tcdm_to_axi_master_bridge

Overview:
- Converts one 32-bit XBAR_TCDM slave port into single-beat AXI4 master transactions, one transaction at a time.
- This is the reverse direction of the SoC's 64-bit AXI→TCDM plug.
- Used where a TCDM initiator (FC data, debug, uDMA) must reach an AXI-only target, e.g. a custom AXI IP or the cluster plug, without going through the full interconnect.
- Responses return in order on the TCDM r_valid channel; AXI error responses map to r_opc.

Parameters:
- AXI_ID_WIDTH, 1, width of AW/AR/B/R IDs; all issued IDs are 0.
- AXI_USER_WIDTH, 6, width of user fields; driven 0.
- AXI_PROT, 3'b000, constant AxPROT value.
- Address and data widths are fixed localparams: 32 and 32.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- tcdm_req_i  in  1  request
- tcdm_add_i  in  32  byte address
- tcdm_wen_i  in  1  1=read, 0=write
- tcdm_wdata_i  in  32  write data
- tcdm_be_i  in  4  byte enables
- tcdm_gnt_o  out  1  grant
- tcdm_r_valid_o  out  1  response valid, one pulse per granted request
- tcdm_r_rdata_o  out  32  read data
- tcdm_r_opc_o  out  1  1 = SLVERR/DECERR
- aw_valid_o/aw_ready_i, aw_addr_o[32], aw_id_o[AXI_ID_WIDTH]  AXI write address channel
- w_valid_o/w_ready_i, w_data_o[32], w_strb_o[4], w_last_o  AXI write data channel
- b_valid_i/b_ready_o, b_resp_i[2], b_id_i  AXI write response channel
- ar_valid_o/ar_ready_i, ar_addr_o[32], ar_id_o  AXI read address channel
- r_valid_i/r_ready_o, r_data_i[32], r_resp_i[2], r_id_i, r_last_i  AXI read data channel
- Fixed-value outputs:
  - Ax_len=0, Ax_size=3'b010, Ax_burst=INCR, Ax_lock/cache/qos/region=0, Ax_prot=AXI_PROT, Ax_user/w_user=0, aw_atop=0.
  - Declared as normal output ports.

Behaviour:
- Reset: all outputs 0; state IDLE.
- States:
  - IDLE: tcdm_gnt_o = tcdm_req_i (combinational).
    - On req & gnt, register add, wen, wdata and be.
    - Write (wen=0) → WRITE; read (wen=1) → RD_ADDR.
  - WRITE: aw_valid_o and w_valid_o both asserted from the next cycle.
    - Each drops independently after its own handshake; AW and W may complete in either order or the same cycle.
    - When both are done → WR_RESP.
    - w_last_o=1 whenever w_valid_o=1.
  - WR_RESP: b_ready_o=1. On b_valid_i → RESP, capturing opc = b_resp_i[1].
  - RD_ADDR: ar_valid_o=1 until ar_ready_i → RD_DATA.
  - RD_DATA: r_ready_o=1. On r_valid_i → RESP, capturing r_data_i and opc = r_resp_i[1].
  - RESP: tcdm_r_valid_o=1 for exactly one cycle with registered rdata/opc; writes return rdata=0. Then → IDLE.
- Valid stability: aw/w/ar valid and payload are held stable until the handshake; valid is never withdrawn.
- tcdm_gnt_o is 0 in every state except IDLE. At most one transaction is outstanding.
- Minimum latency with zero-wait AXI: grant at cycle 0, AW/W at 1, B at 2, r_valid at 3. Throughput is one transaction per 4 cycles.
- Address is passed unaligned-as-is. be=0 write is still issued, with strb=0.
- b_id/r_id are ignored; r_last_i is ignored (len=0).
- Reset mid-transaction returns to IDLE immediately and drops all valids. A pending AXI response is lost; system reset covers both ends.

Optional Feature:
- Macro: TCDM2AXI_ERR_LOG_EN.
- When defined:
  - Adds ports err_valid_o (1), err_addr_o (32), err_is_write_o (1) and err_clr_i (1).
  - The first error response latches address and direction; err_valid_o goes sticky high.
  - Later errors are ignored while err_valid_o=1.
  - err_clr_i clears the log next cycle; if it coincides with a new error, the new error is captured.
- When undefined: the ports are absent and there is no extra logic.

Decomposition:
- Package tcdm2axi_pkg holds:
  - state_t enum (IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RESP)
  - AXI_SIZE_4B, AXI_BURST_INCR
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
- The error log is a natural sub-module, tcdm2axi_err_log, instantiated only under the macro.

Test Plan:
- Write 0x1A10_0004, wdata 0xDEADBEEF, be 0xF; AW/W/B ready immediately → gnt at cycle 0, AW+W at cycle 1 (strb 0xF, len 0, size 2), r_valid at cycle 3 with opc=0.
- Read 0x1A10_0008; ar_ready delayed 3 cycles, R returns 0x12345678 OKAY → ar_valid held stable 4 cycles, r_rdata=0x12345678, opc=0, gnt low throughout.
- Write with w_ready arriving 2 cycles before aw_ready, then reversed → B is accepted only after both handshakes; exactly one r_valid per case.
- Read returning SLVERR, then DECERR → opc=1 each time. With TCDM2AXI_ERR_LOG_EN: err_addr holds the first address only; err_clr_i then clears err_valid.
- Back-to-back requests held high → the second gnt comes only after the first r_valid cycle; no overlap of AXI valids.
- rst_i asserted in WR_RESP → next cycle all valids 0, state IDLE, a fresh read completes normally.
